ring_ctrl_mt: RTL

RING_CTRL_MT -- requirements
Module: ring_ctrl_mt

---
 rtl/ring_ctrl_mt.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ring_ctrl_mt.sv
// Ring stop for a multithreaded core: routes ring requests and responses, injects
// core requests through a local FIFO and tracks outstanding reads per thread.
package ring_ctrl_mt_pkg;
    typedef enum logic [1:0] {RD = 2'd0, WR = 2'd1, RD_RSP = 2'd2, WR_RSP = 2'd3} t_opcode;
endpackage

module ring_ctrl_mt
    import ring_ctrl_mt_pkg::*;
#(
    parameter  int unsigned NUM_THREADS = 4,
    parameter  int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned TID_W       = $clog2(NUM_THREADS),
    localparam int unsigned REQ_W       = 8 + TID_W
) (
    input  logic                   QClk,
    input  logic                   RstQnnnH,
    input  logic [7:0]             CoreID,
    input  logic                   RingReqInValid,
    input  logic [REQ_W-1:0]       RingReqInRequestor,
    input  t_opcode                RingReqInOpcode,
    input  logic [31:0]            RingReqInAddress,
    input  logic [31:0]            RingReqInData,
    input  logic                   RingRspInValid,
    input  logic [REQ_W-1:0]       RingRspInRequestor,
    input  t_opcode                RingRspInOpcode,
    input  logic [31:0]            RingRspInAddress,
    input  logic [31:0]            RingRspInData,
    output logic                   RingReqOutValid,
    output logic [REQ_W-1:0]       RingReqOutRequestor,
    output t_opcode                RingReqOutOpcode,
    output logic [31:0]            RingReqOutAddress,
    output logic [31:0]            RingReqOutData,
    output logic                   RingRspOutValid,
    output logic [REQ_W-1:0]       RingRspOutRequestor,
    output t_opcode                RingRspOutOpcode,
    output logic [31:0]            RingRspOutAddress,
    output logic [31:0]            RingRspOutData,
    input  logic                   C2F_ReqValid,
    input  t_opcode                C2F_ReqOpcode,
    input  logic [TID_W-1:0]       C2F_ReqThreadID,
    input  logic [31:0]            C2F_ReqAddress,
    input  logic [31:0]            C2F_ReqData,
    output logic                   C2F_RspValid,
    output t_opcode                C2F_RspOpcode,
    output logic [TID_W-1:0]       C2F_RspThreadID,
    output logic [31:0]            C2F_RspData,
    output logic                   C2F_RspStall,
    output logic                   F2C_ReqValid,
    output t_opcode                F2C_ReqOpcode,
    output logic [31:0]            F2C_ReqAddress,
    output logic [31:0]            F2C_ReqData,
    output logic [NUM_THREADS-1:0] RdPending,
    output logic                   OvfErr
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic             valid;
        logic [REQ_W-1:0] requestor;
        t_opcode          opcode;
        logic [31:0]      address;
        logic [31:0]      data;
    } ring_msg_t;

    typedef struct packed {
        logic        valid;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } f2c_req_t;

    typedef struct packed {
        logic             valid;
        t_opcode          opcode;
        logic [TID_W-1:0] tid;
        logic [31:0]      data;
    } c2f_rsp_t;

    typedef struct packed {
        t_opcode          opcode;
        logic [TID_W-1:0] tid;
        logic [31:0]      address;
        logic [31:0]      data;
    } fifo_ent_t;

    ring_msg_t              req_out_q, req_out_d, rsp_out_q, rsp_out_d;
    f2c_req_t               f2c_q, f2c_d;
    c2f_rsp_t               c2f_q, c2f_d;
    logic [NUM_THREADS-1:0] pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    fifo_ent_t              mem_q [FIFO_DEPTH];
    fifo_ent_t              head;
    logic                   req_hit, req_fwd, rsp_hit, fifo_full, push, pop;

    assign req_hit   = RingReqInValid && (RingReqInAddress[31:24] == CoreID);
    assign req_fwd   = RingReqInValid && !req_hit;
    assign rsp_hit   = RingRspInValid && (RingRspInRequestor[REQ_W-1:TID_W] == CoreID);
    assign fifo_full = (cnt_q == FULL_CNT);
    // Free slot = no forwarded request this cycle; a full FIFO that pops still refuses the push.
    assign pop       = !req_fwd && (cnt_q != '0);
    assign push      = C2F_ReqValid && !fifo_full;
    assign head      = mem_q[rptr_q];

    always_comb begin
        req_out_d = '0;
        if (req_fwd) begin
            req_out_d = '{1'b1, RingReqInRequestor, RingReqInOpcode, RingReqInAddress, RingReqInData};
        end else if (pop) begin
            req_out_d = '{1'b1, {CoreID, head.tid}, head.opcode, head.address, head.data};
        end

        f2c_d = '0;
        if (req_hit) begin
            f2c_d = '{1'b1, RingReqInOpcode, RingReqInAddress, RingReqInData};
        end

        rsp_out_d = '0;
        c2f_d     = '0;
        if (rsp_hit) begin
            c2f_d = '{1'b1, RingRspInOpcode, RingRspInRequestor[TID_W-1:0], RingRspInData};
        end else if (RingRspInValid) begin
            rsp_out_d = '{1'b1, RingRspInRequestor, RingRspInOpcode, RingRspInAddress, RingRspInData};
        end

        // Clear first so a same-cycle set on the same thread wins.
        pend_d = pend_q;
        if (rsp_hit && (RingRspInOpcode == RD_RSP)) begin
            pend_d[RingRspInRequestor[TID_W-1:0]] = 1'b0;
        end
        if (pop && (head.opcode == RD)) begin
            pend_d[head.tid] = 1'b1;
        end

        ovf_d  = ovf_q | (C2F_ReqValid & fifo_full);
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            req_out_q <= '0;
            rsp_out_q <= '0;
            f2c_q     <= '0;
            c2f_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            req_out_q <= req_out_d;
            rsp_out_q <= rsp_out_d;
            f2c_q     <= f2c_d;
            c2f_q     <= c2f_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge QClk) begin
        if (push) begin
            mem_q[wptr_q] <= '{C2F_ReqOpcode, C2F_ReqThreadID, C2F_ReqAddress, C2F_ReqData};
        end
    end

    assign RingReqOutValid     = req_out_q.valid;
    assign RingReqOutRequestor = req_out_q.requestor;
    assign RingReqOutOpcode    = req_out_q.opcode;
    assign RingReqOutAddress   = req_out_q.address;
    assign RingReqOutData      = req_out_q.data;
    assign RingRspOutValid     = rsp_out_q.valid;
    assign RingRspOutRequestor = rsp_out_q.requestor;
    assign RingRspOutOpcode    = rsp_out_q.opcode;
    assign RingRspOutAddress   = rsp_out_q.address;
    assign RingRspOutData      = rsp_out_q.data;
    assign F2C_ReqValid        = f2c_q.valid;
    assign F2C_ReqOpcode       = f2c_q.opcode;
    assign F2C_ReqAddress      = f2c_q.address;
    assign F2C_ReqData         = f2c_q.data;
    assign C2F_RspValid        = c2f_q.valid;
    assign C2F_RspOpcode       = c2f_q.opcode;
    assign C2F_RspThreadID     = c2f_q.tid;
    assign C2F_RspData         = c2f_q.data;
    assign C2F_RspStall        = fifo_full;
    assign RdPending           = pend_q;
    assign OvfErr              = ovf_q;
endmodule
